// File: rtl/dct_if.sv
// Handshake and address/strobe bundle between the DCT control FSM and its datapath.
interface dct_if #(
  parameter int unsigned MEL_AW  = 5,
  parameter int unsigned CEP_AW  = 4,
  parameter int unsigned COEF_AW = 9
);
  logic               dct_start;
  logic               dct_abort;
  logic [MEL_AW-1:0]  mel_addr;
  logic [COEF_AW-1:0] coef_addr;
  logic               acc_clr;
  logic               mul_en;
  logic               add_en;
  logic [CEP_AW-1:0]  cep_addr;
  logic               write_cep_en;
  logic               busy;
  logic               dct_done;

  // Upstream/observer side: issues start/abort, sees the controller outputs.
  modport master (
    output dct_start, dct_abort,
    input  mel_addr, coef_addr, acc_clr, mul_en, add_en,
    input  cep_addr, write_cep_en, busy, dct_done
  );

  // Controller side.
  modport slave (
    input  dct_start, dct_abort,
    output mel_addr, coef_addr, acc_clr, mul_en, add_en,
    output cep_addr, write_cep_en, busy, dct_done
  );
endinterface

// File: rtl/dct_state_ctrl.sv
// DCT stage sequencer: for each cepstral index k, accumulates logmel[n]*coef[k][n]
// over all n using the shared multi-cycle multiplier/adder, then writes cep[k].
module dct_state_ctrl #(
  parameter int unsigned NUM_MEL     = 26,
  parameter int unsigned NUM_CEP     = 13,
  parameter int unsigned MEL_AW      = 5,
  parameter int unsigned CEP_AW      = 4,
  parameter int unsigned COEF_AW     = 9,
  parameter int unsigned LOOPS_MUL   = 10,
  parameter int unsigned LOOPS_ADD   = 10,
  parameter int unsigned LOOPS_WRITE = 2
) (
  input  logic clk,
  input  logic rst_n,
  dct_if.slave bus
);

  localparam int unsigned TW = 4;
  localparam logic [MEL_AW-1:0]  N_LAST   = MEL_AW'(NUM_MEL - 1);
  localparam logic [CEP_AW-1:0]  K_LAST   = CEP_AW'(NUM_CEP - 1);
  localparam logic [COEF_AW-1:0] BASE_INC = COEF_AW'(NUM_MEL);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_READ, S_MUL, S_ADD, S_WRITE, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [TW-1:0]      timer, timer_nx;
  logic [MEL_AW-1:0]  n, n_nx;
  logic [CEP_AW-1:0]  k, k_nx;
  logic [COEF_AW-1:0] base, base_nx;

  logic [MEL_AW-1:0]  mel_addr_q, mel_addr_nx;
  logic [COEF_AW-1:0] coef_addr_q, coef_addr_nx;
  logic [CEP_AW-1:0]  cep_addr_q, cep_addr_nx;
  logic acc_clr_q, acc_clr_nx;
  logic mul_en_q, mul_en_nx;
  logic add_en_q, add_en_nx;
  logic write_q, write_nx;
  logic busy_q, busy_nx;
  logic done_q, done_nx;

  // State, loop counters and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      n           <= '0;
      k           <= '0;
      base        <= '0;
      mel_addr_q  <= '0;
      coef_addr_q <= '0;
      cep_addr_q  <= '0;
      acc_clr_q   <= 1'b0;
      mul_en_q    <= 1'b0;
      add_en_q    <= 1'b0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      n           <= n_nx;
      k           <= k_nx;
      base        <= base_nx;
      mel_addr_q  <= mel_addr_nx;
      coef_addr_q <= coef_addr_nx;
      cep_addr_q  <= cep_addr_nx;
      acc_clr_q   <= acc_clr_nx;
      mul_en_q    <= mul_en_nx;
      add_en_q    <= add_en_nx;
      write_q     <= write_nx;
      busy_q      <= busy_nx;
      done_q      <= done_nx;
    end
  end

  // Next-state/counter update, then output decode of the upcoming state so the
  // output registers always reflect the current state.
  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    n_nx         = n;
    k_nx         = k;
    base_nx      = base;
    mel_addr_nx  = '0;
    coef_addr_nx = '0;
    cep_addr_nx  = '0;
    acc_clr_nx   = 1'b0;
    mul_en_nx    = 1'b0;
    add_en_nx    = 1'b0;
    write_nx     = 1'b0;
    done_nx      = 1'b0;

    if (state != S_IDLE && bus.dct_abort) begin
      state_nx = S_IDLE;
      timer_nx = '0;
      n_nx     = '0;
      k_nx     = '0;
      base_nx  = '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.dct_start && !bus.dct_abort) state_nx = S_CLR;
        S_CLR: begin
          n_nx     = '0;
          state_nx = S_READ;
        end
        S_READ: begin
          timer_nx = TW'(LOOPS_MUL - 1);
          state_nx = S_MUL;
        end
        S_MUL: begin
          if (timer == '0) begin
            timer_nx = TW'(LOOPS_ADD - 1);
            state_nx = S_ADD;
          end else begin
            timer_nx = timer - TW'(1);
          end
        end
        S_ADD: begin
          if (timer != '0) begin
            timer_nx = timer - TW'(1);
          end else if (n == N_LAST) begin
            timer_nx = TW'(LOOPS_WRITE - 1);
            state_nx = S_WRITE;
          end else begin
            n_nx     = n + MEL_AW'(1);
            state_nx = S_READ;
          end
        end
        S_WRITE: begin
          if (timer != '0) begin
            timer_nx = timer - TW'(1);
          end else if (k == K_LAST) begin
            state_nx = S_DONE;
          end else begin
            k_nx     = k + CEP_AW'(1);
            base_nx  = base + BASE_INC;
            state_nx = S_CLR;
          end
        end
        S_DONE: begin
          timer_nx = '0;
          n_nx     = '0;
          k_nx     = '0;
          base_nx  = '0;
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    unique case (state_nx)
      S_CLR:   acc_clr_nx = 1'b1;
      S_READ, S_MUL, S_ADD: begin
        mel_addr_nx  = n_nx;
        coef_addr_nx = base_nx + COEF_AW'(n_nx);
        mul_en_nx    = (state_nx == S_MUL);
        add_en_nx    = (state_nx == S_ADD);
      end
      S_WRITE: begin
        write_nx    = 1'b1;
        cep_addr_nx = k_nx;
      end
      S_DONE:  done_nx = 1'b1;
      default: ;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  assign bus.mel_addr     = mel_addr_q;
  assign bus.coef_addr    = coef_addr_q;
  assign bus.cep_addr     = cep_addr_q;
  assign bus.acc_clr      = acc_clr_q;
  assign bus.mul_en       = mul_en_q;
  assign bus.add_en       = add_en_q;
  assign bus.write_cep_en = write_q;
  assign bus.busy         = busy_q;
  assign bus.dct_done     = done_q;

endmodule
